// File: rtl/clock_disp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clock_disp_ctrl_pkg
// Shared definitions for the clock / display sequencer:
//   - mode_e        : RUN and the three SET states; the encoding is also the
//                     value driven on the mode output
//   - DIG_OFF       : digit vector for a blanked digit
//   - HR_MAX/MS_MAX : BCD wrap limits for hours and for minutes/seconds
//   - dig_vec()     : packs enable/value/decimal point into a 6-bit digit vector
// Digit vector layout: [5]=enable (active-high), [4:1]=value, [0]=dp (active-low).
// ----------------------------------------------------------------------------
package clock_disp_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_SET_H = 2'b01,
      MODE_SET_M = 2'b10,
      MODE_SET_S = 2'b11
   } mode_e;

   localparam logic [5:0] DIG_OFF = 6'b000001;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   // dp_on=1 lights the decimal point, which is active-low on the wire.
   function automatic logic [5:0] dig_vec(input logic       en,
                                          input logic [3:0] val,
                                          input logic       dp_on);
      return {en, val, ~dp_on};
   endfunction

endpackage

// File: rtl/clock_disp_ctrl_bcd2_cnt.sv
// ----------------------------------------------------------------------------
// bcd2_cnt
// Two-digit BCD up/down counter that wraps between 00 and a BCD limit.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset (value -> 00)
//   inc_i, dec_i   : count up / down by one; both together do nothing
//   clr_i          : synchronous clear to 00, overrides inc/dec
//   max_i[7:0]     : BCD wrap limit {tens, units}, e.g. 8'h23 or 8'h59
//   tens_o, units_o: current value
//   carry_o        : combinational, high in the cycle an increment wraps max->00
// ----------------------------------------------------------------------------
module bcd2_cnt (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       clr_i,
   input  logic [7:0] max_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       carry_o
);

   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       at_max, at_zero, do_inc, do_dec;

   assign at_max  = ({tens_q, units_q} == max_i);
   assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);
   assign do_inc  = inc_i & ~dec_i & ~clr_i;
   assign do_dec  = dec_i & ~inc_i & ~clr_i;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (clr_i) begin
         tens_d  = 4'd0;
         units_d = 4'd0;
      end else if (do_inc) begin
         if (at_max) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = 4'd0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end else if (do_dec) begin
         // Below 00 the field jumps straight to its limit (00 -> 23 / 59).
         if (at_zero) begin
            tens_d  = max_i[7:4];
            units_d = max_i[3:0];
         end else if (units_q == 4'd0) begin
            tens_d  = tens_q - 4'd1;
            units_d = 4'd9;
         end else begin
            units_d = units_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens_o  = tens_q;
   assign units_o = units_q;
   assign carry_o = do_inc & at_max;

endmodule

// File: rtl/clock_disp_ctrl.sv
// ----------------------------------------------------------------------------
// clock_disp_ctrl
// Timekeeping and display sequencer for the 8-digit multiplexed display.
// Keeps HH:MM:SS in BCD, runs a RUN/SET_H/SET_M/SET_S mode FSM from three
// debounced buttons and produces the eight digit vectors for the driver.
// Parameters:
//   TICK_COUNT  : clock cycles per one-second tick
//   BLINK_COUNT : clock cycles per blink-phase toggle of the selected field
// Ports:
//   clock_i            : system clock
//   reset_i            : asynchronous active-high reset
//   btn_mode_i/_inc_i/_dec_i : debounced button levels, act on rising edges
//   d1_o..d8_o         : digit vectors, d1 leftmost; d1/d2 always blank,
//                        d3d4 hours, d5d6 minutes, d7d8 seconds (registered)
//   mode_o             : 00 RUN, 01 SET_H, 10 SET_M, 11 SET_S (registered)
//   sec_tick_o         : one-cycle pulse per counted second in RUN
// ----------------------------------------------------------------------------
module clock_disp_ctrl
   import clock_disp_ctrl_pkg::*;
#(
   parameter int TICK_COUNT  = 100_000_000,
   parameter int BLINK_COUNT = 25_000_000
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       btn_mode_i,
   input  logic       btn_inc_i,
   input  logic       btn_dec_i,
   output logic [5:0] d1_o,
   output logic [5:0] d2_o,
   output logic [5:0] d3_o,
   output logic [5:0] d4_o,
   output logic [5:0] d5_o,
   output logic [5:0] d6_o,
   output logic [5:0] d7_o,
   output logic [5:0] d8_o,
   output logic [1:0] mode_o,
   output logic       sec_tick_o
);

   localparam int PW = (TICK_COUNT  > 1) ? $clog2(TICK_COUNT)  : 1;
   localparam int BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_COUNT - 1);

   // Button edge detection
   logic btn_mode_q, btn_inc_q, btn_dec_q;
   logic mode_rise, inc_rise, dec_rise;
   logic mode_ev, inc_ev, dec_ev;

   // FSM
   mode_e state_q, state_d;
   logic  run, sel_h, sel_m, sel_s;

   // Prescaler and blink
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;

   // Time fields
   logic       hr_inc, hr_dec, mn_inc, mn_dec, sc_inc, sc_dec;
   logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
   logic       mn_carry, sc_carry, hr_carry_unused;

   // Output registers
   logic [5:0] d3_q, d4_q, d5_q, d6_q, d7_q, d8_q;
   logic [1:0] mode_q;
   logic       sec_tick_q;
   logic       en_h, en_m, en_s;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         btn_mode_q <= 1'b0;
         btn_inc_q  <= 1'b0;
         btn_dec_q  <= 1'b0;
      end else begin
         btn_mode_q <= btn_mode_i;
         btn_inc_q  <= btn_inc_i;
         btn_dec_q  <= btn_dec_i;
      end
   end

   assign mode_rise = btn_mode_i & ~btn_mode_q;
   assign inc_rise  = btn_inc_i  & ~btn_inc_q;
   assign dec_rise  = btn_dec_i  & ~btn_dec_q;

   // A mode press swallows any inc/dec in the same cycle, and inc+dec together
   // cancel out, so at most one event type is ever active.
   assign mode_ev = mode_rise;
   assign inc_ev  = inc_rise & ~dec_rise & ~mode_rise;
   assign dec_ev  = dec_rise & ~inc_rise & ~mode_rise;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= MODE_RUN;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (mode_ev) begin
         case (state_q)
            MODE_RUN:   state_d = MODE_SET_H;
            MODE_SET_H: state_d = MODE_SET_M;
            MODE_SET_M: state_d = MODE_SET_S;
            MODE_SET_S: state_d = MODE_RUN;
            default:    state_d = MODE_RUN;
         endcase
      end
   end

   // ---------------- FSM: decoded outputs ----------------
   always_comb begin
      run   = 1'b0;
      sel_h = 1'b0;
      sel_m = 1'b0;
      sel_s = 1'b0;
      case (state_q)
         MODE_RUN:   run   = 1'b1;
         MODE_SET_H: sel_h = 1'b1;
         MODE_SET_M: sel_m = 1'b1;
         MODE_SET_S: sel_s = 1'b1;
         default:    run   = 1'b1;
      endcase
   end

   // Prescaler is parked at 0 outside RUN, so returning to RUN always gives a
   // full TICK_COUNT period before the first second.
   always_comb begin
      presc_d = presc_q;
      tick    = 1'b0;
      if (run) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = '0;
      end
   end

   // Blink restarts in the visible phase whenever the user acts, so the
   // edited field is always shown immediately after a press.
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (mode_ev || (!run && (inc_ev || dec_ev))) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + BW'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         presc_q       <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         presc_q       <= presc_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // Carries ripple only in RUN; in SET each field wraps on its own.
   assign sc_inc = tick | (sel_s & inc_ev);
   assign sc_dec = sel_s & dec_ev;
   assign mn_inc = (run & sc_carry) | (sel_m & inc_ev);
   assign mn_dec = sel_m & dec_ev;
   assign hr_inc = (run & mn_carry) | (sel_h & inc_ev);
   assign hr_dec = sel_h & dec_ev;

   bcd2_cnt u_sec (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .inc_i   (sc_inc),
      .dec_i   (sc_dec),
      .clr_i   (1'b0),
      .max_i   (MS_MAX),
      .tens_o  (sc_t),
      .units_o (sc_u),
      .carry_o (sc_carry)
   );

   bcd2_cnt u_min (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .inc_i   (mn_inc),
      .dec_i   (mn_dec),
      .clr_i   (1'b0),
      .max_i   (MS_MAX),
      .tens_o  (mn_t),
      .units_o (mn_u),
      .carry_o (mn_carry)
   );

   // Hours roll over 23 -> 00 with nothing further to carry into.
   bcd2_cnt u_hr (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .inc_i   (hr_inc),
      .dec_i   (hr_dec),
      .clr_i   (1'b0),
      .max_i   (HR_MAX),
      .tens_o  (hr_t),
      .units_o (hr_u),
      .carry_o (hr_carry_unused)
   );

   assign en_h = sel_h ? blink_phase_q : 1'b1;
   assign en_m = sel_m ? blink_phase_q : 1'b1;
   assign en_s = sel_s ? blink_phase_q : 1'b1;

   // Output stage: one cycle behind the time/FSM registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         d3_q       <= dig_vec(1'b1, 4'd0, 1'b0);
         d4_q       <= dig_vec(1'b1, 4'd0, 1'b1);
         d5_q       <= dig_vec(1'b1, 4'd0, 1'b0);
         d6_q       <= dig_vec(1'b1, 4'd0, 1'b1);
         d7_q       <= dig_vec(1'b1, 4'd0, 1'b0);
         d8_q       <= dig_vec(1'b1, 4'd0, 1'b0);
         mode_q     <= MODE_RUN;
         sec_tick_q <= 1'b0;
      end else begin
         d3_q       <= dig_vec(en_h, hr_t, 1'b0);
         d4_q       <= dig_vec(en_h, hr_u, 1'b1);
         d5_q       <= dig_vec(en_m, mn_t, 1'b0);
         d6_q       <= dig_vec(en_m, mn_u, 1'b1);
         d7_q       <= dig_vec(en_s, sc_t, 1'b0);
         d8_q       <= dig_vec(en_s, sc_u, 1'b0);
         mode_q     <= state_q;
         sec_tick_q <= tick;
      end
   end

   assign d1_o       = DIG_OFF;
   assign d2_o       = DIG_OFF;
   assign d3_o       = d3_q;
   assign d4_o       = d4_q;
   assign d5_o       = d5_q;
   assign d6_o       = d6_q;
   assign d7_o       = d7_q;
   assign d8_o       = d8_q;
   assign mode_o     = mode_q;
   assign sec_tick_o = sec_tick_q;

endmodule

// File: tb/tb_clock_disp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clock_disp_ctrl
// Directed bench for clock_disp_ctrl with TICK_COUNT=10, BLINK_COUNT=4.
// A behavioural clock model (binary hh/mm/ss) predicts the registered outputs
// of every cycle; predictions are queued when the inputs for a cycle are set
// and popped once that clock edge has produced the outputs.
// ----------------------------------------------------------------------------
module tb_clock_disp_ctrl;

   localparam int TICK  = 10;
   localparam int BLINK = 4;

   localparam logic [50:0] RST_VEC = {6'b000001, 6'b000001, 6'b100001, 6'b100000,
                                      6'b100001, 6'b100000, 6'b100001, 6'b100001,
                                      2'b00, 1'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bm = 1'b0, bi = 1'b0, bd = 1'b0;
   logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
   logic [1:0] mode;
   logic       stick;

   always #5 clk = ~clk;

   clock_disp_ctrl #(.TICK_COUNT(TICK), .BLINK_COUNT(BLINK)) dut (
      .clock_i    (clk),
      .reset_i    (rst),
      .btn_mode_i (bm),
      .btn_inc_i  (bi),
      .btn_dec_i  (bd),
      .d1_o       (d1),
      .d2_o       (d2),
      .d3_o       (d3),
      .d4_o       (d4),
      .d5_o       (d5),
      .d6_o       (d6),
      .d7_o       (d7),
      .d8_o       (d8),
      .mode_o     (mode),
      .sec_tick_o (stick)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          tick_seen = 0;
   logic [50:0] sb_q[$];

   // Model state
   int m_state, m_hh, m_mm, m_ss, m_presc, m_bcnt;
   bit m_phase, m_pm, m_pi, m_pd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] dv(input bit en, input int v, input bit dp_on);
      return {en, 4'(v), ~dp_on};
   endfunction

   function automatic logic [50:0] model_vec(input bit tk);
      bit eh, em, es;
      eh = (m_state == 1) ? m_phase : 1'b1;
      em = (m_state == 2) ? m_phase : 1'b1;
      es = (m_state == 3) ? m_phase : 1'b1;
      return {6'b000001, 6'b000001,
              dv(eh, m_hh / 10, 1'b0), dv(eh, m_hh % 10, 1'b1),
              dv(em, m_mm / 10, 1'b0), dv(em, m_mm % 10, 1'b1),
              dv(es, m_ss / 10, 1'b0), dv(es, m_ss % 10, 1'b0),
              2'(m_state), tk};
   endfunction

   function automatic logic [50:0] dut_vec();
      return {d1, d2, d3, d4, d5, d6, d7, d8, mode, stick};
   endfunction

   task automatic model_reset();
      m_state = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_bcnt = 0;
      m_phase = 1'b1; m_pm = 1'b0; m_pi = 1'b0; m_pd = 1'b0;
      sb_q.delete();
   endtask

   // One clock: predict, advance the model, clock the DUT, compare.
   task automatic cyc();
      bit mev, ir, dr, iev, dev, tk;
      logic [50:0] exp;
      mev = bm && !m_pm;
      ir  = bi && !m_pi;
      dr  = bd && !m_pd;
      iev = ir && !dr && !mev;
      dev = dr && !ir && !mev;
      tk  = (m_state == 0) && (m_presc == TICK - 1);
      sb_q.push_back(model_vec(tk));
      if (m_state == 0) begin
         m_presc = tk ? 0 : m_presc + 1;
         if (tk) begin
            m_ss++;
            if (m_ss == 60) begin
               m_ss = 0; m_mm++;
               if (m_mm == 60) begin
                  m_mm = 0; m_hh = (m_hh + 1) % 24;
               end
            end
         end
      end else begin
         m_presc = 0;
         if (iev || dev) begin
            case (m_state)
               1: m_hh = (m_hh + (iev ? 1 : 23)) % 24;
               2: m_mm = (m_mm + (iev ? 1 : 59)) % 60;
               default: m_ss = (m_ss + (iev ? 1 : 59)) % 60;
            endcase
         end
      end
      if (mev || ((iev || dev) && m_state != 0)) begin
         m_bcnt = 0; m_phase = 1'b1;
      end else if (m_bcnt == BLINK - 1) begin
         m_bcnt = 0; m_phase = !m_phase;
      end else begin
         m_bcnt++;
      end
      if (mev) m_state = (m_state + 1) % 4;
      m_pm = bm; m_pi = bi; m_pd = bd;
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      check("cycle_outputs", 64'(dut_vec()), 64'(exp));
      if (stick) tick_seen++;
   endtask

   task automatic press(input bit pm_, input bit pi_, input bit pd_);
      bm = pm_; bi = pi_; bd = pd_;
      cyc();
      bm = 1'b0; bi = 1'b0; bd = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state (asynchronous, before any clock edge)
      #1 rst = 1'b1;
      #2;
      check("reset_outputs", 64'(dut_vec()), 64'(RST_VEC));
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // First second after reset release
      tick_seen = 0;
      repeat (11) cyc();
      check("first_sec_ticks", 64'(tick_seen), 64'(1));
      check("d8_one_sec", 64'(d8), 64'(6'b100011));
      check("d1_off", 64'(d1), 64'(6'b000001));
      check("d2_off", 64'(d2), 64'(6'b000001));
      check("d4_dp_lit", 64'(d4[0]), 64'(1'b0));

      // Set 23:59:58, then run through midnight
      press(1, 0, 0);                         // SET_H
      press(0, 0, 1);                         // 00 -> 23
      press(1, 0, 0);                         // SET_M
      press(0, 0, 1);                         // 00 -> 59
      press(1, 0, 0);                         // SET_S
      repeat (3) press(0, 0, 1);              // 01 -> 58
      check("preset_hours", 64'({d3[4:1], d4[4:1]}), 64'(8'h23));
      check("preset_mins",  64'({d5[4:1], d6[4:1]}), 64'(8'h59));
      check("preset_secs",  64'({d7[4:1], d8[4:1]}), 64'(8'h58));
      tick_seen = 0;
      press(1, 0, 0);                         // RUN
      repeat (20) cyc();
      check("midnight_ticks", 64'(tick_seen), 64'(2));
      check("midnight_digits", 64'({d3, d4, d5, d6, d7, d8}),
            64'({6'b100001, 6'b100000, 6'b100001, 6'b100000, 6'b100001, 6'b100001}));

      // Hours wrap in SET_H and blink of the selected field
      press(1, 0, 0);                         // SET_H
      repeat (25) press(0, 1, 0);
      check("hours_inc_wrap", 64'({d3[4:1], d4[4:1]}), 64'(8'h01));
      repeat (2) press(0, 0, 1);
      check("hours_dec_wrap", 64'({d3[4:1], d4[4:1]}), 64'(8'h23));
      check("secs_frozen", 64'({d7[4:1], d8[4:1]}), 64'(8'h00));
      for (int i = 2; i <= 9; i++) begin
         cyc();
         check("blink_d3_en", 64'(d3[5]), 64'((((i - 1) / 4) % 2) == 0));
         check("blink_d4_en", 64'(d4[5]), 64'((((i - 1) / 4) % 2) == 0));
         check("unselected_en", 64'(d7[5]), 64'(1'b1));
      end

      // Simultaneous events in SET_M
      press(1, 0, 0);                         // SET_M
      press(0, 1, 1);
      check("inc_dec_cancel", 64'({d5[4:1], d6[4:1]}), 64'(8'h00));
      press(1, 1, 0);
      check("mode_wins_mode", 64'(mode), 64'(2'b11));
      check("mode_wins_mins", 64'({d5[4:1], d6[4:1]}), 64'(8'h00));

      // Held inc counts once; first tick after returning to RUN
      bi = 1'b1;
      repeat (50) cyc();
      bi = 1'b0;
      cyc();
      check("held_inc_once", 64'({d7[4:1], d8[4:1]}), 64'(8'h01));
      bm = 1'b1;
      cyc();
      bm = 1'b0;
      tick_seen = 0;
      n = 0;
      while (tick_seen == 0 && n < 30) begin
         cyc();
         n++;
      end
      check("first_tick_latency", 64'(n), 64'(10));

      // Asynchronous reset while in SET_H with the blink phase low
      press(1, 0, 0);                         // SET_H
      repeat (4) cyc();
      check("pre_reset_blink_low", 64'(d3[5]), 64'(1'b0));
      check("pre_reset_mode", 64'(mode), 64'(2'b01));
      #2 rst = 1'b1;
      #1;
      check("async_reset", 64'(dut_vec()), 64'(RST_VEC));
      @(posedge clk);
      #1;
      check("reset_held", 64'(dut_vec()), 64'(RST_VEC));
      rst = 1'b0;
      model_reset();
      tick_seen = 0;
      repeat (12) cyc();
      check("post_reset_ticks", 64'(tick_seen), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
